// File: rtl/uparc_pipe_ctl.sv
// Pipeline interlock controller: load-use / HI-LO hazard stalls, bus-wait freeze,
// multi-cycle mul/div sequencing and a saturating stall-cycle counter.
module uparc_pipe_ctl #(
  parameter int unsigned REGNO_WIDTH  = 5,
  parameter int unsigned MD_CYCLES    = 32,
  parameter int unsigned MD_CNT_WIDTH = 6,
  parameter int unsigned PERF_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic [REGNO_WIDTH-1:0] rs_p1,
  input  logic                   rs_used_p1,
  input  logic [REGNO_WIDTH-1:0] rt_p1,
  input  logic                   rt_used_p1,
  input  logic                   mfhilo_p1,
  input  logic                   md_start_p1,
  input  logic [REGNO_WIDTH-1:0] rd_p2,
  input  logic                   load_p2,
  input  logic                   bus_wait_p3,
  input  logic                   flush,
  output logic                   stall_p0,
  output logic                   stall_p1,
  output logic                   bubble_p2,
  output logic                   stall_all,
  output logic                   md_go,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [PERF_WIDTH-1:0]  stall_cycles
);

  typedef enum logic {IDLE, MDBUSY} state_t;

  localparam logic [MD_CNT_WIDTH-1:0] MD_LOAD = MD_CNT_WIDTH'(MD_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [MD_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [PERF_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;

  logic busy, done, lu, mh, hz_stall, p1_hold, accept;

  always_comb begin
    busy     = (state_q == MDBUSY);
    done     = busy && (cnt_q == '0);
    lu       = load_p2 && (rd_p2 != '0) &&
               ((rs_used_p1 && (rs_p1 == rd_p2)) || (rt_used_p1 && (rt_p1 == rd_p2)));
    mh       = (mfhilo_p1 || md_start_p1) && busy && !done;
    hz_stall = !flush && (lu || mh);
    p1_hold  = bus_wait_p3 || hz_stall;
    accept   = md_start_p1 && !flush && !p1_hold;
  end

  // Combinational controls are forced low while reset is held, not just the registers.
  always_comb begin
    stall_all = nrst && bus_wait_p3;
    stall_p0  = nrst && p1_hold;
    stall_p1  = nrst && p1_hold;
    bubble_p2 = nrst && !bus_wait_p3 && hz_stall;
    md_go     = nrst && accept;
    md_busy   = nrst && busy;
    md_done   = nrst && done;
    stall_cycles = stall_cnt_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MDBUSY;
          cnt_d   = MD_LOAD;
        end
      end
      MDBUSY: begin
        if (cnt_q == '0) begin
          if (accept) begin
            cnt_d = MD_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - MD_CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (p1_hold && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_uparc_pipe_ctl.sv
// Bench for uparc_pipe_ctl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a remaining-cycles model.
module tb_uparc_pipe_ctl;

  localparam int unsigned RW  = 5;
  localparam int unsigned MDC = 4;
  localparam int unsigned CW  = 6;
  localparam int unsigned PW  = 6;
  localparam int unsigned SAT = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          nrst;
  logic [RW-1:0] rs_p1, rt_p1, rd_p2;
  logic          rs_used_p1, rt_used_p1, mfhilo_p1, md_start_p1;
  logic          load_p2, bus_wait_p3, flush;
  logic          stall_p0, stall_p1, bubble_p2, stall_all;
  logic          md_go, md_busy, md_done;
  logic [PW-1:0] stall_cycles;

  always #5 clk = ~clk;

  uparc_pipe_ctl #(
    .REGNO_WIDTH (RW),
    .MD_CYCLES   (MDC),
    .MD_CNT_WIDTH(CW),
    .PERF_WIDTH  (PW)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .rs_p1       (rs_p1),
    .rs_used_p1  (rs_used_p1),
    .rt_p1       (rt_p1),
    .rt_used_p1  (rt_used_p1),
    .mfhilo_p1   (mfhilo_p1),
    .md_start_p1 (md_start_p1),
    .rd_p2       (rd_p2),
    .load_p2     (load_p2),
    .bus_wait_p3 (bus_wait_p3),
    .flush       (flush),
    .stall_p0    (stall_p0),
    .stall_p1    (stall_p1),
    .bubble_p2   (bubble_p2),
    .stall_all   (stall_all),
    .md_go       (md_go),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .stall_cycles(stall_cycles)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_left = busy cycles still to come (incl. current), m_stalls = perf count.
  int m_left;
  int m_stalls;
  logic e_lu, e_mh, e_hz, e_stall_all, e_stall, e_bubble, e_go, e_busy, e_done;

  assign e_lu = load_p2 && (rd_p2 != 0) &&
                ((rs_used_p1 && rs_p1 == rd_p2) || (rt_used_p1 && rt_p1 == rd_p2));
  assign e_mh        = (mfhilo_p1 || md_start_p1) && (m_left > 1);
  assign e_hz        = !flush && (e_lu || e_mh);
  assign e_stall_all = nrst && bus_wait_p3;
  assign e_stall     = nrst && (bus_wait_p3 || e_hz);
  assign e_bubble    = nrst && !bus_wait_p3 && e_hz;
  assign e_go        = nrst && md_start_p1 && !flush && !e_stall;
  assign e_busy      = nrst && (m_left > 0);
  assign e_done      = nrst && (m_left == 1);

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_left   = 0;
      m_stalls = 0;
    end else begin
      if (e_stall && m_stalls < SAT) m_stalls = m_stalls + 1;
      if (e_go) m_left = MDC;
      else if (m_left > 0) m_left = m_left - 1;
    end
  end

  always @(negedge clk) begin
    check("stall_p0",     64'(stall_p0),     64'(e_stall));
    check("stall_p1",     64'(stall_p1),     64'(e_stall));
    check("bubble_p2",    64'(bubble_p2),    64'(e_bubble));
    check("stall_all",    64'(stall_all),    64'(e_stall_all));
    check("md_go",        64'(md_go),        64'(e_go));
    check("md_busy",      64'(md_busy),      64'(e_busy));
    check("md_done",      64'(md_done),      64'(e_done));
    check("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
  end

  task automatic idle_in();
    rs_p1 = '0; rt_p1 = '0; rd_p2 = '0;
    rs_used_p1 = 1'b0; rt_used_p1 = 1'b0; mfhilo_p1 = 1'b0; md_start_p1 = 1'b0;
    load_p2 = 1'b0; bus_wait_p3 = 1'b0; flush = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lu_in();
    load_p2 = 1'b1; rd_p2 = 5'd8; rs_p1 = 5'd8; rs_used_p1 = 1'b1;
  endtask

  initial begin
    idle_in();
    nrst = 1'b0;
    bus_wait_p3 = 1'b1;
    lu_in();
    #12;
    check("rst_stall_all", 64'(stall_all), 0);
    check("rst_stall_p1",  64'(stall_p1), 0);
    check("rst_count",     64'(stall_cycles), 0);
    check("rst_busy",      64'(md_busy), 0);
    step(); nrst = 1'b1; idle_in();

    step(); lu_in(); #5;
    check("lu_stall_p0", 64'(stall_p0), 1);
    check("lu_stall_p1", 64'(stall_p1), 1);
    check("lu_bubble",   64'(bubble_p2), 1);
    check("lu_stall_all", 64'(stall_all), 0);
    step(); idle_in(); #5;
    check("lu_clear",  64'(stall_p1), 0);
    check("lu_count",  64'(stall_cycles), 1);

    step(); load_p2 = 1'b1; rd_p2 = '0; rs_p1 = '0; rs_used_p1 = 1'b1; #5;
    check("r0_nostall", 64'(stall_p1), 0);
    step(); rd_p2 = 5'd9; rt_p1 = 5'd9; rt_used_p1 = 1'b0; rs_p1 = 5'd3; #5;
    check("unused_nostall", 64'(stall_p1), 0);

    step(); idle_in(); md_start_p1 = 1'b1; #5;
    check("md_go_c0",   64'(md_go), 1);
    check("md_busy_c0", 64'(md_busy), 0);
    step(); md_start_p1 = 1'b0; #5;
    check("md_busy_c1", 64'(md_busy), 1);
    step(); mfhilo_p1 = 1'b1; #5;
    check("mh_stall_c2", 64'(stall_p1), 1);
    check("mh_bubble_c2", 64'(bubble_p2), 1);
    step(); #5;
    check("mh_stall_c3", 64'(stall_p1), 1);
    check("md_done_c3",  64'(md_done), 0);
    step(); md_start_p1 = 1'b1; #5;
    check("md_done_c4",  64'(md_done), 1);
    check("mh_stall_c4", 64'(stall_p1), 0);
    check("md_go_b2b",   64'(md_go), 1);
    for (int k = 5; k <= 8; k++) begin
      step(); md_start_p1 = 1'b0; mfhilo_p1 = 1'b0; #5;
      check("b2b_busy", 64'(md_busy), 1);
      check("b2b_done", 64'(md_done), (k == 8) ? 64'd1 : 64'd0);
    end
    step(); #5;
    check("b2b_idle", 64'(md_busy), 0);

    step(); bus_wait_p3 = 1'b1; lu_in(); #5;
    check("prio_stall_all", 64'(stall_all), 1);
    check("prio_bubble",    64'(bubble_p2), 0);
    check("prio_stall_p0",  64'(stall_p0), 1);
    step(); bus_wait_p3 = 1'b0; flush = 1'b1; #5;
    check("flush_stall_p1", 64'(stall_p1), 0);
    check("flush_bubble",   64'(bubble_p2), 0);

    step(); idle_in(); md_start_p1 = 1'b1;
    step(); md_start_p1 = 1'b0;
    step(); #2; nrst = 1'b0; #1;
    check("arst_busy",  64'(md_busy), 0);
    check("arst_count", 64'(stall_cycles), 0);
    step(); nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(); #5;
      check("arst_no_done", 64'(md_done), 0);
    end

    step(); bus_wait_p3 = 1'b1;
    repeat (70) step();
    #5;
    check("sat_count", 64'(stall_cycles), 64'(SAT));
    step(); idle_in();

    for (int n = 0; n < 3000; n++) begin
      step();
      rs_p1       = RW'($urandom_range(0, 3));
      rt_p1       = RW'($urandom_range(0, 3));
      rd_p2       = RW'($urandom_range(0, 3));
      rs_used_p1  = 1'($urandom_range(0, 1));
      rt_used_p1  = 1'($urandom_range(0, 1));
      load_p2     = 1'($urandom_range(0, 1));
      mfhilo_p1   = ($urandom_range(0, 3) == 0);
      md_start_p1 = ($urandom_range(0, 5) == 0);
      bus_wait_p3 = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2; nrst = 1'b0; #2; nrst = 1'b1;
      end
    end

    step(); idle_in();
    step();
    #5;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uparc_pipe_ctl.md
Name: uparc_pipe_ctl

Overview:
Pipeline interlock controller for the 4-stage core (p0 fetch, p1 decode, p2 execute, p3 memory). It decides when the forwarding path cannot supply a valid operand and the pipeline must stall. It also sequences the multi-cycle multiply/divide unit. Outputs are the stage stall/bubble controls consumed by the fetch, decode and execute stage registers.

Parameters:
REGNO_WIDTH, 5, register number width
MD_CYCLES, 32, mul/div latency in cycles (range 2..2^MD_CNT_WIDTH)
MD_CNT_WIDTH, 6, mul/div down-counter width
PERF_WIDTH, 32, stall-cycle counter width

Ports:
clk  in  1  core clock
nrst  in  1  asynchronous active-low reset
rs_p1  in  REGNO_WIDTH  decode-stage rs number
rs_used_p1  in  1  decode instruction reads rs
rt_p1  in  REGNO_WIDTH  decode-stage rt number
rt_used_p1  in  1  decode instruction reads rt
mfhilo_p1  in  1  decode instruction reads HI/LO
md_start_p1  in  1  decode instruction issues mul/div
rd_p2  in  REGNO_WIDTH  execute-stage destination
load_p2  in  1  execute stage holds a memory load
bus_wait_p3  in  1  memory stage waiting on bus
flush  in  1  redirect/exception; decode instruction is killed this cycle
stall_p0  out  1  hold PC/fetch register
stall_p1  out  1  hold decode register
bubble_p2  out  1  load NOP into execute register
stall_all  out  1  freeze entire pipeline
md_go  out  1  one-cycle pulse: start mul/div unit
md_busy  out  1  mul/div in progress
md_done  out  1  one-cycle pulse: last mul/div cycle, HI/LO valid next edge
stall_cycles  out  PERF_WIDTH  saturating count of cycles with stall_p1=1

Behaviour:
- Reset (nrst=0, async): state IDLE, counter 0, stall_cycles 0. All outputs 0 while in reset.
- All stall outputs are combinational from the inputs and registered state. No added latency.
- Load-use hazard (lu): load_p2 & rd_p2!=0 & ((rs_used_p1 & rs_p1==rd_p2) | (rt_used_p1 & rt_p1==rd_p2)).
- MD hazard (mh): (mfhilo_p1 | md_start_p1) & md_busy & !md_done.
- Priority:
  1. bus_wait_p3: stall_all=stall_p0=stall_p1=1, bubble_p2=0.
  2. else if !flush & (lu | mh): stall_p0=stall_p1=bubble_p2=1.
  3. else: all 0.
- flush suppresses lu/mh stalls, never bus-wait stalls.
- md accepted = md_start_p1 & !flush & !stall_p1. md_go = md accepted (same cycle).
- FSM:
  - IDLE: on accept -> MDBUSY, counter <= MD_CYCLES-1.
  - MDBUSY: md_busy=1. Counter decrements every cycle, including during stall_all; flush does not abort.
  - counter==0 in MDBUSY: md_done=1. Next state IDLE, unless a new accept occurs that same cycle, in which case stay MDBUSY and reload MD_CYCLES-1.
  - md_busy stays high for exactly MD_CYCLES cycles after the accept edge.
- stall_cycles increments on each clk edge with stall_p1=1 and saturates at all-ones.
- Reset asserted mid-operation aborts mul/div immediately. No md_done is issued.

Test Plan:
- Load-use: load_p2=1, rd_p2=8, rs_p1=8, rs_used_p1=1 -> stall_p0=stall_p1=bubble_p2=1 for that cycle. Next cycle, load_p2=0 -> all 0, stall_cycles=1.
- r0/unused: rd_p2=0 with rs_p1=0 -> no stall. rd_p2=9, rt_p1=9, rt_used_p1=0 -> no stall.
- Mul/div, MD_CYCLES=4: md_start_p1 at cycle 0 -> md_go=1. md_busy high for cycles 1-4, md_done=1 at cycle 4. mfhilo_p1 held from cycle 2 -> stall in cycles 2-3, none in cycle 4.
- Back-to-back: a second md_start_p1 in the md_done cycle is accepted without stall. md_busy stays high continuously for another 4 cycles.
- Priority: bus_wait_p3=1 together with lu=1 -> stall_all=1, bubble_p2=0. flush=1 with lu=1 and bus_wait_p3=0 -> all stalls 0.
- Async reset: drop nrst with counter=2 in MDBUSY -> md_busy=0 and stall_cycles=0 immediately. No md_done pulse afterwards.
